// File: rtl/gb_rom_overlay_arb.sv
// -----------------------------------------------------------------------------
// gb_rom_overlay_arb
//
// Purpose:
//   Arbitrates the low-ROM read path between the CPU and the OAM DMA engine.
//   Each granted access is sequenced through a fixed four-cycle pipeline
//   (SETUP, STROBE, CAPTURE, ack) into either the 256-byte boot ROM or the
//   cartridge ROM port. The choice depends on the boot-overlay state. A CPU
//   write to HIDE_ADR becomes the boot ROM's hide-register write pulse.
//
// Configuration macro:
//   GB_BOOT_HIDE_BIT0_EN - when defined, a write to HIDE_ADR pulses
//                          o_boot_write_reg only if the write data bit 0 is 1.
//                          With bit 0 clear, the write completes and acks,
//                          but no strobe is issued.
//                          When undefined, any write to HIDE_ADR pulses
//                          o_boot_write_reg.
//
// Parameters:
//   HIDE_ADR  I/O address whose write hides the boot ROM overlay
//   OVL_PAGE  upper address byte of the overlay window
//
// Ports:
//   i_clk, i_reset       clock; synchronous active-high reset
//   i_cpu_*/o_cpu_ack    CPU master: level request, we/adr/din, ack pulse
//   i_dma_*/o_dma_ack    DMA master: level read request, adr, ack pulse
//   o_rdata              read data, valid with ack, held until the next ack
//   o_boot_*/i_boot_*    boot ROM: address, read strobe, data, hide register
//                        write, hidden flag
//   o_cart_*/i_cart_*    cartridge bus: address, read/write strobes, data
// -----------------------------------------------------------------------------
module gb_rom_overlay_arb #(
   parameter logic [15:0] HIDE_ADR = 16'hFF50,
   parameter logic [7:0]  OVL_PAGE = 8'h00
) (
   input  logic        i_clk,
   input  logic        i_reset,
   // CPU master
   input  logic        i_cpu_req,
   input  logic        i_cpu_we,
   input  logic [15:0] i_cpu_adr,
   input  logic [7:0]  i_cpu_din,
   output logic        o_cpu_ack,
   // DMA master (read-only)
   input  logic        i_dma_req,
   input  logic [15:0] i_dma_adr,
   output logic        o_dma_ack,
   // shared read data
   output logic [7:0]  o_rdata,
   // boot ROM
   output logic [7:0]  o_boot_adr,
   output logic        o_boot_read,
   input  logic [7:0]  i_boot_dout,
   output logic [7:0]  o_boot_din,
   output logic        o_boot_write_reg,
   input  logic        i_boot_hide,
   // cartridge bus
   output logic [15:0] o_cart_adr,
   output logic        o_cart_rd,
   output logic        o_cart_wr,
   input  logic [7:0]  i_cart_dout,
   output logic [7:0]  o_cart_din
);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_SETUP,
      ST_STROBE,
      ST_CAPTURE
   } state_t;

   // Route and operation of one access. The value is decided once at grant
   // time and stays frozen until the access finishes.
   typedef enum logic [2:0] {
      ACC_BOOT_RD,   // overlay read from the boot ROM
      ACC_CART_RD,   // read from the cartridge
      ACC_HIDE_WR,   // CPU write to HIDE_ADR -> hide register pulse
      ACC_CART_WR,   // any other CPU write
      ACC_NONE       // completes and acks without any strobe
   } acc_t;

   typedef enum logic {
      GNT_CPU = 1'b0,
      GNT_DMA = 1'b1
   } gnt_t;

   // ---------------------------------------------------------------------------
   // Registered state
   // ---------------------------------------------------------------------------
   state_t r_state;
   acc_t   r_kind;
   gnt_t   r_owner;
   gnt_t   r_last_grant;

   // ---------------------------------------------------------------------------
   // Grant selection and route decode (combinational, used only in IDLE)
   // ---------------------------------------------------------------------------
   logic        w_cpu_elig;
   logic        w_dma_elig;
   logic        w_grant_valid;
   gnt_t        w_grant;
   logic        w_sel_we;
   logic [15:0] w_sel_adr;
   logic [7:0]  w_sel_din;
   logic        w_overlay;
   logic        w_hide_ok;
   acc_t        w_sel_kind;

   always_comb begin
      // NOTE: every signal gets a default before any branch, so no path can
      // leave a value unassigned and infer a latch.
      w_grant   = GNT_CPU;
      w_sel_we  = 1'b0;
      w_sel_adr = 16'h0000;
      w_sel_din = 8'h00;
      w_hide_ok = 1'b1;

      // A requester whose ack is high still has its req up for this cycle.
      // It must not be granted again for the access that just finished.
      w_cpu_elig    = i_cpu_req && !o_cpu_ack;
      w_dma_elig    = i_dma_req && !o_dma_ack;
      w_grant_valid = w_cpu_elig || w_dma_elig;

      if (w_cpu_elig && w_dma_elig) begin
         // Tie: favour whoever did not win last time.
         if (r_last_grant == GNT_CPU) begin
            w_grant = GNT_DMA;
         end else begin
            w_grant = GNT_CPU;
         end
      end else if (w_dma_elig) begin
         w_grant = GNT_DMA;
      end

      if (w_grant == GNT_CPU) begin
         w_sel_we  = i_cpu_we;
         w_sel_adr = i_cpu_adr;
         w_sel_din = i_cpu_din;
      end else begin
         w_sel_adr = i_dma_adr;
      end

      // DMA follows the same overlay rule as the CPU.
      w_overlay = !i_boot_hide && (w_sel_adr[15:8] == OVL_PAGE);

`ifdef GB_BOOT_HIDE_BIT0_EN
      w_hide_ok = w_sel_din[0];
`endif

      if (!w_sel_we) begin
         w_sel_kind = w_overlay ? ACC_BOOT_RD : ACC_CART_RD;
      end else if (w_sel_adr == HIDE_ADR) begin
         // A hide write never falls through to the cartridge.
         w_sel_kind = w_hide_ok ? ACC_HIDE_WR : ACC_NONE;
      end else begin
         w_sel_kind = ACC_CART_WR;
      end
   end

   // ---------------------------------------------------------------------------
   // Access sequencer. All outputs are registers. Each output is loaded on
   // the edge that enters the state in which it must be visible.
   // ---------------------------------------------------------------------------
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         // Aborts any access in flight. The aborted access never acks.
         r_state          <= ST_IDLE;
         r_kind           <= ACC_NONE;
         r_owner          <= GNT_CPU;
         r_last_grant     <= GNT_DMA;
         o_cpu_ack        <= 1'b0;
         o_dma_ack        <= 1'b0;
         o_rdata          <= 8'h00;
         o_boot_adr       <= 8'h00;
         o_boot_read      <= 1'b0;
         o_boot_din       <= 8'h00;
         o_boot_write_reg <= 1'b0;
         o_cart_adr       <= 16'h0000;
         o_cart_rd        <= 1'b0;
         o_cart_wr        <= 1'b0;
         o_cart_din       <= 8'h00;
      end else begin
         // NOTE: sequential state uses non-blocking assignments only. A later
         // assignment in the same cycle overrides the default pulse clear
         // below without creating a race between blocks.
         o_cpu_ack <= 1'b0;
         o_dma_ack <= 1'b0;

         case (r_state)
            ST_IDLE: begin
               if (w_grant_valid) begin
                  r_owner      <= w_grant;
                  r_last_grant <= w_grant;
                  r_kind       <= w_sel_kind;
                  // Address and data are presented during SETUP and held
                  // through STROBE. Only the port that is used gets updated.
                  case (w_sel_kind)
                     ACC_BOOT_RD: o_boot_adr <= w_sel_adr[7:0];
                     ACC_CART_RD: o_cart_adr <= w_sel_adr;
                     ACC_CART_WR: begin
                        o_cart_adr <= w_sel_adr;
                        o_cart_din <= w_sel_din;
                     end
                     ACC_HIDE_WR: o_boot_din <= w_sel_din;
                     default:     ;
                  endcase
                  r_state <= ST_SETUP;
               end
            end

            ST_SETUP: begin
               // At most one strobe is raised for exactly the STROBE cycle.
               o_boot_read      <= (r_kind == ACC_BOOT_RD);
               o_cart_rd        <= (r_kind == ACC_CART_RD);
               o_boot_write_reg <= (r_kind == ACC_HIDE_WR);
               o_cart_wr        <= (r_kind == ACC_CART_WR);
               r_state          <= ST_STROBE;
            end

            ST_STROBE: begin
               // The boot ROM and the cartridge register their read data on
               // this edge, so it is stable throughout CAPTURE.
               o_boot_read      <= 1'b0;
               o_cart_rd        <= 1'b0;
               o_boot_write_reg <= 1'b0;
               o_cart_wr        <= 1'b0;
               r_state          <= ST_CAPTURE;
            end

            ST_CAPTURE: begin
               case (r_kind)
                  ACC_BOOT_RD: o_rdata <= i_boot_dout;
                  ACC_CART_RD: o_rdata <= i_cart_dout;
                  default:     ;  // writes leave the last read data intact
               endcase
               if (r_owner == GNT_CPU) begin
                  o_cpu_ack <= 1'b1;
               end else begin
                  o_dma_ack <= 1'b1;
               end
               r_state <= ST_IDLE;
            end

            default: r_state <= ST_IDLE;
         endcase
      end
   end

endmodule
